imem_boot_loader: RTL and testbench

- Host-side boot and run controller for the multi-cycle CPU.
- Accepts a program as a valid/ready word stream and writes it into the CPU instruction memory through its write port.
- While loading, holds the CPU in reset with its clock enable low. After loading, releases the CPU, counts run cycles and stops the CPU on the halt PC or on a timeout.
- Sits between the host/bench stimulus and the top-level CPU wrapper, in the opposite direction to the halt/result observer.

---
 rtl/imem_boot_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot/run controller: streams a program into the CPU instruction memory,
// holds the CPU in reset while loading, then runs it until the halt PC or a timeout.
module imem_boot_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] HALT_PC     = 32'h0000_0054,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000,
  parameter int unsigned RST_HOLD    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              host_valid,
  input  logic [31:0]       host_data,
  input  logic              host_last,
  output logic              host_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              cpu_clk_en,
  input  logic [31:0]       cpu_pc,
  input  logic [31:0]       dmem_word0,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [7:0]        result,
  output logic [31:0]       cycle_count
);

  // state   | meaning
  // IDLE    | no program loaded yet, waiting for the first word
  // LOAD    | writing accepted words to consecutive addresses
  // HOLD    | program loaded, CPU kept in reset for RST_HOLD cycles
  // RUN     | CPU clocked, counting cycles, watching for halt PC / timeout
  // DONE    | run finished or load overflowed; results held
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = (RST_HOLD > 0) ? HW'(RST_HOLD - 1) : '0;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, state_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic              ready_nxt, we_nxt, rstn_nxt, clken_nxt, busy_nxt;
  logic              done_nxt, timeout_nxt, ovf_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt, count_nxt;
  logic [7:0]        result_nxt;
  logic              accept;
  logic              unused_dmem;

  assign unused_dmem = ^dmem_word0[31:8];
  assign accept      = host_valid && host_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      host_ready  <= 1'b1;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_rstn    <= 1'b0;
      cpu_clk_en  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      result      <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      host_ready  <= ready_nxt;
      imem_we     <= we_nxt;
      imem_addr   <= addr_nxt;
      imem_wdata  <= wdata_nxt;
      cpu_rstn    <= rstn_nxt;
      cpu_clk_en  <= clken_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      timeout     <= timeout_nxt;
      overflow    <= ovf_nxt;
      result      <= result_nxt;
      cycle_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    we_nxt      = 1'b0;
    addr_nxt    = imem_addr;
    wdata_nxt   = imem_wdata;
    rstn_nxt    = cpu_rstn;
    clken_nxt   = cpu_clk_en;
    done_nxt    = done;
    timeout_nxt = timeout;
    ovf_nxt     = overflow;
    result_nxt  = result;
    count_nxt   = cycle_count;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          we_nxt      = 1'b1;
          addr_nxt    = '0;
          wdata_nxt   = host_data;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          ovf_nxt     = 1'b0;
          result_nxt  = '0;
          count_nxt   = '0;
          rstn_nxt    = 1'b0;
          clken_nxt   = 1'b0;
          hold_nxt    = HOLD_INIT;
          state_nxt   = host_last ? ST_HOLD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // imem_addr is the last written address here; a full memory rejects the word
          if (imem_addr == ADDR_MAX) begin
            ovf_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            we_nxt    = 1'b1;
            addr_nxt  = imem_addr + 1'b1;
            wdata_nxt = host_data;
            hold_nxt  = HOLD_INIT;
            if (host_last) state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          rstn_nxt  = 1'b1;
          clken_nxt = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (cpu_clk_en) count_nxt = cycle_count + 32'd1;
        if (cpu_pc == HALT_PC) begin
          clken_nxt   = 1'b0;
          result_nxt  = dmem_word0[7:0];
          done_nxt    = 1'b1;
          timeout_nxt = 1'b0;
          state_nxt   = ST_DONE;
        end else if (cycle_count == TIMEOUT_CYC - 32'd1) begin
          clken_nxt   = 1'b0;
          result_nxt  = dmem_word0[7:0];
          done_nxt    = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD) || (state_nxt == ST_DONE);
    busy_nxt  = (state_nxt == ST_LOAD) || (state_nxt == ST_HOLD) || (state_nxt == ST_RUN);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: dut0 uses default parameters,
// dut1 uses ADDR_W=2 and TIMEOUT_CYC=16 for overflow and timeout cases.
module tb_imem_boot_loader;

  localparam logic [31:0] HALT = 32'h0000_0054;
  localparam logic [31:0] IDLE_PC = 32'h0000_0010;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [1:0]       host_valid, host_last;
  logic [1:0][31:0] host_data, cpu_pc, dmem_word0;
  logic [1:0]       host_ready_w, imem_we_w, cpu_rstn_w, cpu_clk_en_w, busy_w, done_w, timeout_w, overflow_w;
  logic [1:0][7:0]  result_w, addr_w;
  logic [1:0][31:0] wdata_w, count_w;
  logic [1:0]       addr_b;

  imem_boot_loader u_dut0 (
    .clk(clk), .rstn(rstn),
    .host_valid(host_valid[0]), .host_data(host_data[0]), .host_last(host_last[0]),
    .host_ready(host_ready_w[0]), .imem_we(imem_we_w[0]), .imem_addr(addr_w[0]),
    .imem_wdata(wdata_w[0]), .cpu_rstn(cpu_rstn_w[0]), .cpu_clk_en(cpu_clk_en_w[0]),
    .cpu_pc(cpu_pc[0]), .dmem_word0(dmem_word0[0]), .busy(busy_w[0]), .done(done_w[0]),
    .timeout(timeout_w[0]), .overflow(overflow_w[0]), .result(result_w[0]),
    .cycle_count(count_w[0])
  );

  imem_boot_loader #(.ADDR_W(2), .TIMEOUT_CYC(32'd16)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .host_valid(host_valid[1]), .host_data(host_data[1]), .host_last(host_last[1]),
    .host_ready(host_ready_w[1]), .imem_we(imem_we_w[1]), .imem_addr(addr_b),
    .imem_wdata(wdata_w[1]), .cpu_rstn(cpu_rstn_w[1]), .cpu_clk_en(cpu_clk_en_w[1]),
    .cpu_pc(cpu_pc[1]), .dmem_word0(dmem_word0[1]), .busy(busy_w[1]), .done(done_w[1]),
    .timeout(timeout_w[1]), .overflow(overflow_w[1]), .result(result_w[1]),
    .cycle_count(count_w[1])
  );
  assign addr_w[1] = {6'd0, addr_b};

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  typedef struct packed {
    logic        timeout, overflow, cpu_rstn, cpu_clk_en;
    logic [7:0]  result;
    logic [31:0] count;
  } dn_t;
  typedef struct packed {
    logic        host_ready, imem_we, cpu_rstn, cpu_clk_en, busy, done, timeout, overflow;
    logic [7:0]  result;
    logic [31:0] count;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } sn_t;

  wr_t wq0[$], wq1[$];
  dn_t dq0[$], dq1[$];
  sn_t sq0[$], sq1[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic sn_t sn_reset();
    sn_t s = '0;
    s.host_ready = 1'b1;
    return s;
  endfunction

  function automatic sn_t sn_load(input logic [7:0] a, input logic [31:0] w);
    sn_t s = '0;
    s.imem_we = 1'b1;
    s.busy    = 1'b1;
    s.addr    = a;
    s.wdata   = w;
    return s;
  endfunction

  function automatic dn_t dn(input logic to, input logic ov, input logic rs, input logic ce,
                             input logic [7:0] r, input logic [31:0] c);
    dn_t e;
    e.timeout = to; e.overflow = ov; e.cpu_rstn = rs; e.cpu_clk_en = ce;
    e.result = r; e.count = c;
    return e;
  endfunction

  task automatic push_wr(input int d, input logic [7:0] a, input logic [31:0] w);
    wr_t x;
    x.addr = a; x.data = w;
    if (d == 0) wq0.push_back(x); else wq1.push_back(x);
  endtask

  task automatic push_dn(input int d, input dn_t e);
    if (d == 0) dq0.push_back(e); else dq1.push_back(e);
  endtask

  task automatic push_sn(input int d, input sn_t s);
    if (d == 0) sq0.push_back(s); else sq1.push_back(s);
  endtask

  // ---------------- monitor ----------------
  logic [1:0] done_q = '0;
  logic [1:0] crst_q = '0;
  int since_wr [2] = '{99, 99};

  task automatic mon(input int d);
    wr_t w; dn_t e; sn_t s; bit have;
    have = 0;
    if (d == 0 && sq0.size() > 0) begin s = sq0.pop_front(); have = 1; end
    if (d == 1 && sq1.size() > 0) begin s = sq1.pop_front(); have = 1; end
    if (have) begin
      chk("snap_host_ready", d, 32'(host_ready_w[d]), 32'(s.host_ready));
      chk("snap_imem_we",    d, 32'(imem_we_w[d]),    32'(s.imem_we));
      chk("snap_cpu_rstn",   d, 32'(cpu_rstn_w[d]),   32'(s.cpu_rstn));
      chk("snap_cpu_clk_en", d, 32'(cpu_clk_en_w[d]), 32'(s.cpu_clk_en));
      chk("snap_busy",       d, 32'(busy_w[d]),       32'(s.busy));
      chk("snap_done",       d, 32'(done_w[d]),       32'(s.done));
      chk("snap_timeout",    d, 32'(timeout_w[d]),    32'(s.timeout));
      chk("snap_overflow",   d, 32'(overflow_w[d]),   32'(s.overflow));
      chk("snap_result",     d, 32'(result_w[d]),     32'(s.result));
      chk("snap_cycle_count",d, count_w[d],           s.count);
      chk("snap_imem_addr",  d, 32'(addr_w[d]),       32'(s.addr));
      chk("snap_imem_wdata", d, wdata_w[d],           s.wdata);
    end
    if (imem_we_w[d] === 1'b1) begin
      since_wr[d] = 0;
      have = 0;
      if (d == 0 && wq0.size() > 0) begin w = wq0.pop_front(); have = 1; end
      if (d == 1 && wq1.size() > 0) begin w = wq1.pop_front(); have = 1; end
      if (!have) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write dut%0d: got write addr %0d data 0x%0h, expected no write", d, addr_w[d], wdata_w[d]);
      end else begin
        chk("wr_addr", d, 32'(addr_w[d]), 32'(w.addr));
        chk("wr_data", d, wdata_w[d], w.data);
      end
    end else if (since_wr[d] < 1000) begin
      since_wr[d]++;
    end
    if (cpu_rstn_w[d] === 1'b1 && crst_q[d] == 1'b0) begin
      chk("release_gap_after_last_write", d, 32'(since_wr[d]), 32'd2);
      chk("release_clk_en", d, 32'(cpu_clk_en_w[d]), 32'd1);
    end
    if (done_w[d] === 1'b1 && done_q[d] == 1'b0) begin
      have = 0;
      if (d == 0 && dq0.size() > 0) begin e = dq0.pop_front(); have = 1; end
      if (d == 1 && dq1.size() > 0) begin e = dq1.pop_front(); have = 1; end
      if (!have) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done dut%0d: got done=1, expected none", d);
      end else begin
        chk("done_timeout",    d, 32'(timeout_w[d]),    32'(e.timeout));
        chk("done_overflow",   d, 32'(overflow_w[d]),   32'(e.overflow));
        chk("done_cpu_rstn",   d, 32'(cpu_rstn_w[d]),   32'(e.cpu_rstn));
        chk("done_cpu_clk_en", d, 32'(cpu_clk_en_w[d]), 32'(e.cpu_clk_en));
        chk("done_result",     d, 32'(result_w[d]),     32'(e.result));
        chk("done_cycle_count",d, count_w[d],           e.count);
        chk("done_busy",       d, 32'(busy_w[d]),       32'd0);
      end
    end
    done_q[d] = (done_w[d] === 1'b1);
    crst_q[d] = (cpu_rstn_w[d] === 1'b1);
  endtask

  initial forever begin
    @(negedge clk);
    mon(0);
    mon(1);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int d, input logic [31:0] data, input logic last);
    bit acc = 0;
    host_valid[d] = 1'b1; host_data[d] = data; host_last[d] = last;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = (host_ready_w[d] === 1'b1);
      cyc(1);
    end
    host_valid[d] = 1'b0; host_last[d] = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL accept_wait dut%0d: word 0x%0h not accepted in 20 cycles, expected acceptance", d, data);
    end
  endtask

  task automatic load_prog(input int d, input int n, input logic [31:0] base, input bit gaps);
    int cap;
    logic [31:0] w;
    cap = (d == 0) ? 256 : 4;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) cyc(1 + (i % 3));
      w = base + 32'(i);
      if (i < cap) push_wr(d, 8'(i), w);
      send_word(d, w, i == n - 1);
    end
    if (n <= cap) push_sn(d, sn_load(8'(n - 1), base + 32'(n - 1)));
  endtask

  task automatic wait_release(input int d);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cpu_clk_en_w[d] === 1'b1) ok = 1;
      else cyc(1);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL release_wait dut%0d: cpu_clk_en still 0 after 20 cycles, expected 1", d);
    end
  endtask

  task automatic wait_done(input int d, input int lim);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (done_w[d] === 1'b1) ok = 1;
      else cyc(1);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL done_wait dut%0d: done still 0 after %0d cycles, expected 1", d, lim);
    end
    cyc(1);
  endtask

  // Halt PC presented during run cycle k (cycle_count==k), so the stop shows count k+1.
  task automatic run_halt(input int d, input int k, input logic [31:0] dm);
    wait_release(d);
    cyc(k);
    cpu_pc[d] = HALT; dmem_word0[d] = dm;
    push_dn(d, dn(1'b0, 1'b0, 1'b1, 1'b0, dm[7:0], 32'(k + 1)));
    cyc(1);
    cpu_pc[d] = IDLE_PC;
    wait_done(d, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    host_valid = '0; host_last = '0; host_data = '0;
    cpu_pc = {IDLE_PC, IDLE_PC}; dmem_word0 = '0;
    cyc(2);
    push_sn(0, sn_reset());
    push_sn(1, sn_reset());
    cyc(1);
    rstn = 1'b1;
    cyc(1);

    // back-to-back 3-word load, halt at run cycle 40
    load_prog(0, 3, 32'hA000_0000, 1'b0);
    run_halt(0, 40, 32'h0000_00AB);

    // same load with 1-3 cycle valid gaps, reloaded from DONE
    load_prog(0, 3, 32'hB100_0000, 1'b1);
    run_halt(0, 5, 32'h1234_5678);

    // timeout after 16 run cycles
    load_prog(1, 1, 32'hC000_0000, 1'b0);
    dmem_word0[1] = 32'h0000_0033;
    push_dn(1, dn(1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 32'd16));
    wait_release(1);
    wait_done(1, 40);

    // halt in the last allowed cycle wins over timeout
    load_prog(1, 2, 32'hC100_0000, 1'b0);
    run_halt(1, 15, 32'h0000_0077);

    // 5 words into a 4-word memory
    push_dn(1, dn(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0));
    load_prog(1, 5, 32'hD000_0000, 1'b0);
    wait_done(1, 10);
    cyc(4);
    chk("overflow_cpu_rstn_held", 1, 32'(cpu_rstn_w[1]), 32'd0);

    // reset in the middle of a run, then a fresh 1-word program
    load_prog(0, 1, 32'hE000_0000, 1'b0);
    wait_release(0);
    cyc(10);
    rstn = 1'b0;
    push_sn(0, sn_reset());
    push_sn(1, sn_reset());
    cyc(2);
    rstn = 1'b1;
    cyc(1);
    load_prog(0, 1, 32'hE100_0000, 1'b0);
    run_halt(0, 3, 32'h0000_005A);

    cyc(5);
    chk("wq_left", 0, 32'(wq0.size()), 32'd0);
    chk("wq_left", 1, 32'(wq1.size()), 32'd0);
    chk("dq_left", 0, 32'(dq0.size()), 32'd0);
    chk("dq_left", 1, 32'(dq1.size()), 32'd0);
    chk("sq_left", 0, 32'(sq0.size()), 32'd0);
    chk("sq_left", 1, 32'(sq1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
